// File: rtl/reg_file_sb.sv
// 16 x DATA_W register file with two combinational read ports, one write port,
// write-to-read bypass and a per-register pending scoreboard for hazard stalls.
module reg_file_sb #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [3:0]        wr,
    input  logic [DATA_W-1:0] wd,
    input  logic [3:0]        rr1,
    input  logic [3:0]        rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              issue_en,
    input  logic [3:0]        issue_reg,
    output logic              stall,
    output logic [NREG-1:0]   pending
);

    localparam int unsigned AW = 4;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_nxt;
    logic              busy1;
    logic              busy2;

    // Storage; R0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (wr != '0)) begin
            regs[wr] <= wd;
        end
    end

    // Scoreboard next state: a new issue supersedes a retiring write to the same register
    always_comb begin
        pending_nxt = pending_q;
        for (int i = 1; i < int'(NREG); i++) begin
            if (issue_en && (issue_reg == AW'(i))) begin
                pending_nxt[i] = 1'b1;
            end else if (reg_write && (wr == AW'(i))) begin
                pending_nxt[i] = 1'b0;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    // Read ports with same-cycle write-back bypass
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rr1 != '0) begin
            rd1 = (reg_write && (wr == rr1)) ? wd : regs[rr1];
        end
        if (rr2 != '0) begin
            rd2 = (reg_write && (wr == rr2)) ? wd : regs[rr2];
        end
    end

    // A source is only a hazard if its write-back is not arriving this cycle
    always_comb begin
        busy1 = (rr1 != '0) && pending_q[rr1] && !(reg_write && (wr == rr1));
        busy2 = (rr2 != '0) && pending_q[rr2] && !(reg_write && (wr == rr2));
        stall = busy1 || busy2;
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, hand-written reset sequences,
// and randomized traffic checked against an array/bitmask reference model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [3:0]  wr;
    logic [15:0] wd;
    logic [3:0]  rr1;
    logic [3:0]  rr2;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        issue_en;
    logic [3:0]  issue_reg;
    logic        stall;
    logic [15:0] pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .NREG(16)) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .wr(wr), .wd(wd),
        .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
        .issue_en(issue_en), .issue_reg(issue_reg),
        .stall(stall), .pending(pending)
    );

    typedef struct {
        logic        rw;
        logic [3:0]  wr;
        logic [15:0] wd;
        logic [3:0]  rr1;
        logic [3:0]  rr2;
        logic        ie;
        logic [3:0]  ir;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic        e_stall;
        logic [15:0] e_pend;
    } vec_t;

    vec_t vecs [13];

    // Reference model state
    logic [15:0] mregs [16];
    logic [15:0] mpend;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rw_i, input logic [3:0] wr_i, input logic [15:0] wd_i,
                         input logic [3:0] rr1_i, input logic [3:0] rr2_i,
                         input logic ie_i, input logic [3:0] ir_i);
        reg_write = rw_i; wr = wr_i; wd = wd_i;
        rr1 = rr1_i; rr2 = rr2_i; issue_en = ie_i; issue_reg = ir_i;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 16'h0;
        if (reg_write && wr == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic m_busy(input logic [3:0] a);
        return (a != 4'd0) && mpend[a] && !(reg_write && wr == a);
    endfunction

    task automatic m_update();
        if (reg_write && wr != 4'd0) mregs[wr] = wd;
        if (reg_write) mpend[wr] = 1'b0;
        if (issue_en) mpend[issue_reg] = 1'b1;
        mpend[0] = 1'b0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
        mpend = 16'h0;
    endtask

    initial begin
        //              rw wr    wd        rr1   rr2   ie ir    rd1       rd2       st  pend
        vecs[0]  = '{1, 4'd2, 16'hABCD, 4'd0, 4'd2, 0, 4'd0, 16'h0000, 16'hABCD, 0, 16'h0000};
        vecs[1]  = '{0, 4'd0, 16'h0000, 4'd2, 4'd2, 0, 4'd0, 16'hABCD, 16'hABCD, 0, 16'h0000};
        vecs[2]  = '{1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1, 4'd0, 16'h0000, 16'h0000, 0, 16'h0000};
        vecs[3]  = '{0, 4'd0, 16'h0000, 4'd0, 4'd2, 1, 4'd5, 16'h0000, 16'hABCD, 0, 16'h0020};
        vecs[4]  = '{0, 4'd0, 16'h0000, 4'd5, 4'd0, 0, 4'd0, 16'h0000, 16'h0000, 1, 16'h0020};
        vecs[5]  = '{1, 4'd5, 16'h1234, 4'd5, 4'd0, 0, 4'd0, 16'h1234, 16'h0000, 0, 16'h0000};
        vecs[6]  = '{1, 4'd7, 16'h7777, 4'd7, 4'd5, 1, 4'd7, 16'h7777, 16'h1234, 0, 16'h0080};
        vecs[7]  = '{0, 4'd0, 16'h0000, 4'd7, 4'd7, 0, 4'd0, 16'h7777, 16'h7777, 1, 16'h0080};
        vecs[8]  = '{0, 4'd0, 16'h0000, 4'd3, 4'd7, 1, 4'd3, 16'h0000, 16'h7777, 1, 16'h0088};
        vecs[9]  = '{1, 4'd7, 16'h0101, 4'd7, 4'd3, 0, 4'd0, 16'h0101, 16'h0000, 1, 16'h0008};
        vecs[10] = '{1, 4'd3, 16'h3333, 4'd3, 4'd0, 1, 4'd3, 16'h3333, 16'h0000, 0, 16'h0008};
        vecs[11] = '{1, 4'd3, 16'h4444, 4'd2, 4'd3, 0, 4'd0, 16'hABCD, 16'h4444, 0, 16'h0000};
        vecs[12] = '{1, 4'd9, 16'h9999, 4'd9, 4'd0, 0, 4'd0, 16'h9999, 16'h0000, 0, 16'h0000};

        rst = 1'b1;
        drive(0, 4'd0, 16'h0, 4'd0, 4'd0, 0, 4'd0);
        #1;
        chk("por_pending", pending, 16'h0);
        chk("por_stall", 16'(stall), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].rw, vecs[v].wr, vecs[v].wd, vecs[v].rr1, vecs[v].rr2,
                  vecs[v].ie, vecs[v].ir);
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", v), rd1, vecs[v].e_rd1);
            chk($sformatf("vec%0d_rd2", v), rd2, vecs[v].e_rd2);
            chk($sformatf("vec%0d_stall", v), 16'(stall), 16'(vecs[v].e_stall));
            @(posedge clk) #1;
            chk($sformatf("vec%0d_pend", v), pending, vecs[v].e_pend);
        end

        // Asynchronous reset with no clock edge: R3 holds 4444 beforehand
        drive(0, 4'd0, 16'h0, 4'd3, 4'd3, 0, 4'd0);
        #2;
        chk("pre_rst_rd1", rd1, 16'h4444);
        rst = 1'b1;
        #1;
        chk("async_rst_rd1", rd1, 16'h0);
        chk("async_rst_rd2", rd2, 16'h0);
        chk("async_rst_pend", pending, 16'h0);
        chk("async_rst_stall", 16'(stall), 16'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Reset mid-flight discards the pending issue and a concurrent issue
        drive(0, 4'd0, 16'h0, 4'd0, 4'd0, 1, 4'd4);
        @(posedge clk) #1;
        chk("issue4_pend", pending, 16'h0010);
        drive(0, 4'd0, 16'h0, 4'd4, 4'd9, 1, 4'd9);
        rst = 1'b1;
        @(posedge clk) #1;
        chk("midrst_pend", pending, 16'h0);
        chk("midrst_rd1", rd1, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'd0, 16'h0, 4'd4, 4'd9, 0, 4'd0);
        #1;
        chk("post_rst_stall", 16'(stall), 16'h0);
        chk("post_rst_rd1", rd1, 16'h0);
        @(posedge clk) #1;
        chk("post_rst_pend", pending, 16'h0);

        // Randomized traffic against the reference model (registers are all 0 after reset)
        m_reset();
        for (int n = 0; n < 1500; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
            @(negedge clk);
            chk("rnd_rd1", rd1, m_read(rr1));
            chk("rnd_rd2", rd2, m_read(rr2));
            chk("rnd_stall", 16'(stall), 16'(m_busy(rr1) || m_busy(rr2)));
            @(posedge clk);
            m_update();
            #1;
            chk("rnd_pend", pending, mpend);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 16-entry general-purpose register file for the RISC datapath.
- It is the consumer of the write-register address produced by the register-destination mux, and it supplies operands to the ALU.
- Two combinational read ports, one synchronous write port, and write-to-read bypass.
- A per-register pending scoreboard: the issue logic marks a destination busy, write-back clears it, and a stall is raised when a source operand is still in flight.

Parameters:
- DATA_W, 16, register and data width in bits.
- NREG, 16, number of registers; fixed by the 4-bit register address field, so only 16 is legal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- reg_write  input  1  write-back enable.
- wr  input  4  write-back register address (from the reg-dst mux).
- wd  input  DATA_W  write-back data.
- rr1  input  4  read address, port 1.
- rr2  input  4  read address, port 2.
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.
- issue_en  input  1  an instruction with a destination is issuing this cycle.
- issue_reg  input  4  destination of the issuing instruction.
- stall  output  1  a source operand is pending and not being written back this cycle.
- pending  output  16  scoreboard bit vector; bit i = register i awaiting write-back.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - All 16 registers clear to 0; pending clears to 0.
  - rd1/rd2 therefore read 0 and stall reads 0.
  - Reset mid-operation discards any write or issue in that cycle.
- R0 is hardwired:
  - Reads of address 0 always return 0.
  - Writes to wr=0 are ignored.
  - issue_reg=0 never sets pending[0]; pending[0] is constant 0.
- Write:
  - On posedge clk with reg_write=1 and wr!=0, regs[wr] <= wd.
  - Latency 1 cycle into storage.
- Read (combinational, 0 latency):
  - rdN = 0 if rrN=0.
  - Otherwise rdN = wd if reg_write=1 and wr=rrN (bypass).
  - Otherwise rdN = regs[rrN].
  - Both ports may address the same register; both return identical data.
- Scoreboard (per register i != 0), on posedge clk:
  - set = issue_en & (issue_reg=i).
  - clr = reg_write & (wr=i).
  - set=1 → pending[i] <= 1. Set wins over a simultaneous clr: the new issue supersedes the retiring write.
  - clr=1 and set=0 → pending[i] <= 0.
  - Otherwise hold.
  - Re-issuing to an already-pending register keeps it pending; only one write-back clears it (no counting).
- Stall (combinational):
  - src_busy(N) = (rrN != 0) & pending[rrN] & ~(reg_write & wr=rrN).
  - stall = src_busy(1) | src_busy(2).
  - A write-back in the same cycle resolves the hazard via bypass, so stall=0.
  - stall does not block issue_en internally; gating issue is the control unit's job.
- Writes of a non-pending register are legal: data updates and pending is unchanged (0 stays 0).
- No X propagation: unknown addresses are not required to be handled; the bench drives only defined values.

Test Plan:
1. Assert rst with all inputs 0, after prior writes to R3 -> rd1=rd2=0 immediately and asynchronously; pending=16'h0000; stall=0.
2. reg_write=1, wr=4'b0010, wd=16'hABCD for one edge, then rr1=2 -> rd1=16'hABCD. In the write cycle itself, rr2=2 -> rd2=16'hABCD via bypass.
3. Write wr=0, wd=16'hFFFF; issue_reg=0 with issue_en=1 -> rd1 (rr1=0) stays 0; pending[0]=0; stall=0.
4. Hazard sequence:
   - Issue issue_reg=5 (one edge) -> pending=16'h0020.
   - Set rr1=5 -> stall=1.
   - Next cycle drive reg_write=1, wr=5, wd=16'h1234 -> stall=0 and rd1=16'h1234 combinationally.
   - After the edge, pending=16'h0000.
5. Same edge: issue_en=1, issue_reg=7 together with reg_write=1, wr=7 -> pending[7]=1 after the edge (set wins); regs[7] holds wd.
6. Issue R4, then assert rst mid-flight with issue_en=1, issue_reg=9 -> pending=0 and registers 0 during reset; after release, rr1=4 gives stall=0 and rd1=0.
